p23_imm_stage: RTL and testbench
================================

# p23_imm_stage

Registered, parametrised successor to the combinational immediate extender. It decodes every RV32/RV64 base immediate format, and optionally the RVC (compressed) formats. The immediate is delivered through a valid/ready handshake with a 2-entry skid buffer, so the decode stage can be retimed without stalling the multicycle core. It sits between instruction fetch/expand and the ALU source mux; `out_instr` travels alongside `immext` for downstream decode.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64; any other value is an elaboration error.
- `RVC`, default 1: 1 enables the compressed immediate codes; 0 makes them illegal.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: upstream offers `instr`/`immsrc`.
- `in_ready` output 1: stage can accept this cycle.
- `instr` input 32: raw instruction; RVC encodings in bits [15:0].
- `immsrc` input 4: format code from `p23_imm_pkg`.
- `out_valid` output 1: `immext`/`out_err`/`out_instr` are valid.
- `out_ready` input 1: downstream accepts.
- `immext` output XLEN: extended immediate.
- `out_err` output 1: `immsrc` was illegal; `immext` is 0 in that case.
- `out_instr` output 32: `instr` carried with its immediate.

## Operation
- Format codes; `i` = `instr`, `sext`/`zext` extend to XLEN:
  - 0 `I`: sext(i[31:20])
  - 1 `S`: sext({i[31:25],i[11:7]})
  - 2 `B`: sext({i[31],i[7],i[30:25],i[11:8],0})
  - 3 `J`: sext({i[31],i[19:12],i[20],i[30:21],0})
  - 4 `U`: sext({i[31:12],12'b0}); RV64 sign-extends from bit 31.
  - 5 `Z`: zext(i[19:15]), the CSR uimm.
  - 8 `CI`: sext({i[12],i[6:2]})
  - 9 `CIW`: zext({i[10:7],i[12:11],i[5],i[6],2'b0})
  - 10 `CLS`: zext({i[5],i[12:10],i[6],2'b0})
  - 11 `CJ`: sext({i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0})
  - 12 `CB`: sext({i[12],i[6:5],i[2],i[11:10],i[4:3],0})
- Illegal codes: 6, 7, 13–15, and 8–12 when `RVC`=0. These produce `immext`=0 and `out_err`=1; the transaction still completes normally and is never dropped.
- Buffer: a main output register plus one skid register.
  - States: EMPTY, ONE, FULL.
  - Accept when `in_valid`&&`in_ready`.
  - Pop when `out_valid`&&`out_ready`.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without pop; the new entry goes to skid.
  - ONE→ONE on simultaneous accept and pop; the main register loads the new entry.
  - ONE→EMPTY on pop without accept.
  - FULL→ONE on pop; skid moves to main. No accept is possible in FULL.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Output signals:
  - `in_ready` = state≠FULL, driven from a register and never combinational from `out_ready`.
  - `out_valid` = state≠EMPTY.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on `out_*` after edge N.
- Throughput is one per cycle while `out_ready`=1.
- Output holds: while `out_valid`=1 and `out_ready`=0, `immext`, `out_err` and `out_instr` stay stable.
- Reset values: `out_valid`=0, `in_ready`=1, `immext`=0, `out_err`=0, `out_instr`=0, state=EMPTY.
- Reset mid-operation discards both entries; outputs reach their reset values asynchronously.
- The first accept is allowed on the first edge after `resetn` deasserts.
- No combinational path from `in_*` to `out_*`.

## Structure
- Package `p23_imm_pkg`: 4-bit format code constants (`IMM_I` … `IMM_CB`) and the legality function, shared with the main decoder.
- Sub-module `p23_imm_gen`: pure combinational `(instr, immsrc) → (immext, err)`, parametrised by `XLEN` and `RVC`.
- The top level instantiates `p23_imm_gen` once at the input and holds only the buffer state machine and registers.

## Test plan
- I-type: `instr`=0xFFF00093, code 0, XLEN=32 → `immext`=0xFFFFFFFF one cycle after accept, `out_err`=0.
- B-type and U-type: 0xFE000EE3 code 2 → 0xFFFFFFFC. Then 0x123450B7 code 4 → 0x12345000. With XLEN=64, 0x800000B7 code 4 → 0xFFFFFFFF80000000.
- RVC gating:
  - c.li x1,-1: `instr`=0x000050FD code 8 → 0xFFFFFFFF.
  - The same stimulus with `RVC`=0 → `immext`=0, `out_err`=1.
  - Code 15 → `out_err`=1 in both configurations.
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back entries. Expect exactly 2 accepted and `in_ready`=0 from the cycle after the second accept. Then `out_ready`=1 drains them in order, and the third entry is accepted when `in_ready` returns to 1.
- Streaming: with `in_valid`=`out_ready`=1 for 16 cycles, 16 outputs appear in order and the state never reaches FULL.
- Reset: assert `resetn`=0 while FULL, asynchronously between edges. `out_valid` drops before the next edge and `in_ready`=1 afterwards; no pre-reset entry appears after release.

Source files
------------

// File: rtl/p23_imm_pkg.sv
// Immediate format codes, buffer states and the legality check shared with the main decoder.
package p23_imm_pkg;

   localparam logic [3:0] IMM_I   = 4'd0;
   localparam logic [3:0] IMM_S   = 4'd1;
   localparam logic [3:0] IMM_B   = 4'd2;
   localparam logic [3:0] IMM_J   = 4'd3;
   localparam logic [3:0] IMM_U   = 4'd4;
   localparam logic [3:0] IMM_Z   = 4'd5;
   localparam logic [3:0] IMM_CI  = 4'd8;
   localparam logic [3:0] IMM_CIW = 4'd9;
   localparam logic [3:0] IMM_CLS = 4'd10;
   localparam logic [3:0] IMM_CJ  = 4'd11;
   localparam logic [3:0] IMM_CB  = 4'd12;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_t;

   // Compressed codes are only legal when the core is built with RVC support.
   function automatic logic imm_legal(input logic [3:0] code, input logic rvc_on);
      logic legal;
      legal = 1'b0;
      case (code)
         IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z:  legal = 1'b1;
         IMM_CI, IMM_CIW, IMM_CLS, IMM_CJ, IMM_CB:  legal = rvc_on;
         default:                                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/p23_imm_gen.sv
// Combinational immediate extraction for RV32/RV64 base and RVC formats.
module p23_imm_gen
   import p23_imm_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RVC  = 1
) (
   input  logic [31:0]     instr,
   input  logic [3:0]      immsrc,
   output logic [XLEN-1:0] immext,
   output logic            err
);

   localparam logic RVC_ON = (RVC != 0);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("p23_imm_gen: XLEN must be 32 or 64");
      end
   endgenerate

   logic unused_opcode_bits;
   assign unused_opcode_bits = ^instr[1:0];

   // Signed width casts give sign extension; unsigned casts give zero extension.
   always_comb begin
      immext = '0;
      err    = 1'b0;
      case (immsrc)
         IMM_I:   immext = XLEN'($signed(instr[31:20]));
         IMM_S:   immext = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:   immext = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_J:   immext = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IMM_U:   immext = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_Z:   immext = XLEN'(instr[19:15]);
         IMM_CI:  immext = XLEN'($signed({instr[12], instr[6:2]}));
         IMM_CIW: immext = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b0});
         IMM_CLS: immext = XLEN'({instr[5], instr[12:10], instr[6], 2'b0});
         IMM_CJ:  immext = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                          instr[2], instr[11], instr[5:3], 1'b0}));
         IMM_CB:  immext = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                          instr[4:3], 1'b0}));
         default: immext = '0;
      endcase
      if (!imm_legal(immsrc, RVC_ON)) begin
         immext = '0;
         err    = 1'b1;
      end
   end

endmodule

// File: rtl/p23_imm_stage.sv
// Registered immediate stage: decode at the input, then a main register plus one skid entry.
module p23_imm_stage
   import p23_imm_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RVC  = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [3:0]      immsrc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] immext,
   output logic            out_err,
   output logic [31:0]     out_instr
);

   buf_state_t      state;
   logic [XLEN-1:0] gen_imm;
   logic            gen_err;
   logic [XLEN-1:0] main_imm;
   logic            main_err;
   logic [31:0]     main_instr;
   logic [XLEN-1:0] skid_imm;
   logic            skid_err;
   logic [31:0]     skid_instr;
   logic            accept;
   logic            pop;

   p23_imm_gen #(
      .XLEN (XLEN),
      .RVC  (RVC)
   ) u_gen (
      .instr  (instr),
      .immsrc (immsrc),
      .immext (gen_imm),
      .err    (gen_err)
   );

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   // in_ready and out_valid are registered alongside the state so neither depends on out_ready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= BUF_EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         main_imm   <= '0;
         main_err   <= 1'b0;
         main_instr <= '0;
         skid_imm   <= '0;
         skid_err   <= 1'b0;
         skid_instr <= '0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (accept) begin
                  main_imm   <= gen_imm;
                  main_err   <= gen_err;
                  main_instr <= instr;
                  out_valid  <= 1'b1;
                  state      <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && !pop) begin
                  skid_imm   <= gen_imm;
                  skid_err   <= gen_err;
                  skid_instr <= instr;
                  in_ready   <= 1'b0;
                  state      <= BUF_FULL;
               end else if (accept && pop) begin
                  main_imm   <= gen_imm;
                  main_err   <= gen_err;
                  main_instr <= instr;
               end else if (pop) begin
                  out_valid  <= 1'b0;
                  state      <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (pop) begin
                  main_imm   <= skid_imm;
                  main_err   <= skid_err;
                  main_instr <= skid_instr;
                  in_ready   <= 1'b1;
                  state      <= BUF_ONE;
               end
            end
            default: begin
               state     <= BUF_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign immext    = main_imm;
   assign out_err   = main_err;
   assign out_instr = main_instr;

endmodule

// File: tb/tb_p23_imm_stage.sv
// Scoreboard bench driving three configurations (RV32+RVC, RV64+RVC, RV32 without RVC) in lockstep.
module tb_p23_imm_stage;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  code;
      logic [31:0] e32;
      logic        err32;
      logic [63:0] e64;
      logic        err64;
      logic [31:0] enr;
      logic        errnr;
   } vec_t;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic [31:0] instr;
   logic [3:0]  immsrc;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_err_a;
   logic [31:0] immext_a, out_instr_a;
   logic        in_ready_b, out_valid_b, out_err_b;
   logic [63:0] immext_b;
   logic [31:0] out_instr_b;
   logic        in_ready_c, out_valid_c, out_err_c;
   logic [31:0] immext_c, out_instr_c;

   vec_t        exp_q[$];
   vec_t        tbl[14];
   vec_t        mon_vec;
   int          checks = 0;
   int          errors = 0;
   logic        hold_valid = 1'b0;
   logic [31:0] hold_imm;
   logic [31:0] hold_instr;

   p23_imm_stage #(.XLEN(32), .RVC(1)) dut_a (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_a),
      .instr(instr), .immsrc(immsrc), .out_valid(out_valid_a), .out_ready(out_ready),
      .immext(immext_a), .out_err(out_err_a), .out_instr(out_instr_a));

   p23_imm_stage #(.XLEN(64), .RVC(1)) dut_b (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_b),
      .instr(instr), .immsrc(immsrc), .out_valid(out_valid_b), .out_ready(out_ready),
      .immext(immext_b), .out_err(out_err_b), .out_instr(out_instr_b));

   p23_imm_stage #(.XLEN(32), .RVC(0)) dut_c (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_c),
      .instr(instr), .immsrc(immsrc), .out_valid(out_valid_c), .out_ready(out_ready),
      .immext(immext_c), .out_err(out_err_c), .out_instr(out_instr_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, input logic [3:0] c,
                               input logic [31:0] e32, input logic err32,
                               input logic [63:0] e64, input logic err64,
                               input logic [31:0] enr, input logic errnr);
      vec_t v;
      v.instr = i;  v.code = c;
      v.e32 = e32;  v.err32 = err32;
      v.e64 = e64;  v.err64 = err64;
      v.enr = enr;  v.errnr = errnr;
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic applyStimulus(input vec_t v, input bit stream_check);
      int wait_cycles;
      wait_cycles = 0;
      instr    = v.instr;
      immsrc   = v.code;
      in_valid = 1'b1;
      if (stream_check) checkOutput("stream_in_ready", {63'b0, in_ready_a}, 64'd1);
      while (!in_ready_a && wait_cycles < 50) begin
         @(posedge clk);
         #1;
         wait_cycles++;
      end
      if (!in_ready_a) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", wait_cycles);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: pops one expectation per handshake and checks hold stability under backpressure.
   always @(negedge clk) begin
      if (!resetn) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid && out_valid_a) begin
            checkOutput("hold_immext", {32'b0, immext_a}, {32'b0, hold_imm});
            checkOutput("hold_instr", {32'b0, out_instr_a}, {32'b0, hold_instr});
         end
         hold_valid = out_valid_a && !out_ready;
         hold_imm   = immext_a;
         hold_instr = out_instr_a;
         if (out_valid_a && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got instr %h, expected no output", out_instr_a);
            end else begin
               mon_vec = exp_q.pop_front();
               checkOutput("imm32", {32'b0, immext_a}, {32'b0, mon_vec.e32});
               checkOutput("err32", {63'b0, out_err_a}, {63'b0, mon_vec.err32});
               checkOutput("instr32", {32'b0, out_instr_a}, {32'b0, mon_vec.instr});
               checkOutput("valid64", {63'b0, out_valid_b}, 64'd1);
               checkOutput("imm64", immext_b, mon_vec.e64);
               checkOutput("err64", {63'b0, out_err_b}, {63'b0, mon_vec.err64});
               checkOutput("valid_norvc", {63'b0, out_valid_c}, 64'd1);
               checkOutput("imm_norvc", {32'b0, immext_c}, {32'b0, mon_vec.enr});
               checkOutput("err_norvc", {63'b0, out_err_c}, {63'b0, mon_vec.errnr});
            end
         end
      end
   end

   initial begin
      tbl[0]  = mk(32'hFFF00093, 4'd0,  32'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0, 32'hFFFFFFFF, 0);
      tbl[1]  = mk(32'hFE000EE3, 4'd2,  32'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC, 0, 32'hFFFFFFFC, 0);
      tbl[2]  = mk(32'h123450B7, 4'd4,  32'h12345000, 0, 64'h0000000012345000, 0, 32'h12345000, 0);
      tbl[3]  = mk(32'h800000B7, 4'd4,  32'h80000000, 0, 64'hFFFFFFFF80000000, 0, 32'h80000000, 0);
      tbl[4]  = mk(32'h000050FD, 4'd8,  32'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0, 32'h0, 1);
      tbl[5]  = mk(32'h12345678, 4'd15, 32'h0, 1, 64'h0, 1, 32'h0, 1);
      tbl[6]  = mk(32'h000F8000, 4'd5,  32'h1F, 0, 64'h1F, 0, 32'h1F, 0);
      tbl[7]  = mk(32'h80000F80, 4'd1,  32'hFFFFF81F, 0, 64'hFFFFFFFFFFFFF81F, 0, 32'hFFFFF81F, 0);
      tbl[8]  = mk(32'h8000006F, 4'd3,  32'hFFF00000, 0, 64'hFFFFFFFFFFF00000, 0, 32'hFFF00000, 0);
      tbl[9]  = mk(32'h00001FE0, 4'd9,  32'h3FC, 0, 64'h3FC, 0, 32'h0, 1);
      tbl[10] = mk(32'h00001C20, 4'd10, 32'h78, 0, 64'h78, 0, 32'h0, 1);
      tbl[11] = mk(32'h00001000, 4'd11, 32'hFFFFF800, 0, 64'hFFFFFFFFFFFFF800, 0, 32'h0, 1);
      tbl[12] = mk(32'h00000044, 4'd12, 32'hA0, 0, 64'hA0, 0, 32'h0, 1);
      tbl[13] = mk(32'h12345678, 4'd6,  32'h0, 1, 64'h0, 1, 32'h0, 1);

      resetn    = 1'b0;
      in_valid  = 1'b0;
      instr     = '0;
      immsrc    = '0;
      out_ready = 1'b1;
      #12;
      checkOutput("rst_out_valid", {63'b0, out_valid_a}, 64'd0);
      checkOutput("rst_in_ready", {63'b0, in_ready_a}, 64'd1);
      checkOutput("rst_immext", {32'b0, immext_a}, 64'd0);
      checkOutput("rst_out_err", {63'b0, out_err_a}, 64'd0);
      checkOutput("rst_out_instr", {32'b0, out_instr_a}, 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Directed formats, streamed back to back
      for (int k = 0; k < 14; k++) applyStimulus(tbl[k], 1'b0);

      // Backpressure: two entries fill the buffer, the third must wait
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++)
         applyStimulus(mk({12'(100 + k), 20'h00093}, 4'd0, 32'(100 + k), 0, 64'(100 + k), 0,
                          32'(100 + k), 0), 1'b0);
      checkOutput("bp_in_ready_full", {63'b0, in_ready_a}, 64'd0);
      checkOutput("bp_out_valid", {63'b0, out_valid_a}, 64'd1);
      instr    = {12'd102, 20'h00093};
      immsrc   = 4'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_in_ready_held", {63'b0, in_ready_a}, 64'd0);
      out_ready = 1'b1;
      applyStimulus(mk({12'd102, 20'h00093}, 4'd0, 32'd102, 0, 64'd102, 0, 32'd102, 0), 1'b0);

      // Streaming: sixteen entries with the buffer never reaching FULL
      for (int k = 1; k <= 16; k++)
         applyStimulus(mk({12'(k), 20'h00093}, 4'd0, 32'(k), 0, 64'(k), 0, 32'(k), 0), 1'b1);

      // Reset while FULL, asserted between edges
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(tbl[0], 1'b0);
      applyStimulus(tbl[1], 1'b0);
      checkOutput("pre_rst_full", {63'b0, in_ready_a}, 64'd0);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      checkOutput("async_out_valid", {63'b0, out_valid_a}, 64'd0);
      checkOutput("async_out_valid64", {63'b0, out_valid_b}, 64'd0);
      checkOutput("async_in_ready", {63'b0, in_ready_a}, 64'd1);
      checkOutput("async_immext", {32'b0, immext_a}, 64'd0);
      checkOutput("async_out_instr", {32'b0, out_instr_a}, 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      out_ready = 1'b1;
      checkOutput("post_rst_in_ready", {63'b0, in_ready_a}, 64'd1);
      applyStimulus(tbl[7], 1'b0);

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("final_out_valid", {63'b0, out_valid_a}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
